// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: the sequencer drives the master side, the datapath/execute stage the slave side.
interface fetch_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
   logic                  START;
   logic [DATA_WIDTH-1:0] INSTR_IN;
   logic [DATA_WIDTH-1:0] ARG_IN;
   logic                  EXEC_READY;
   logic                  COND_IN;
   logic                  CTRL_REG_INSTR;
   logic                  CTRL_REG_ARG;
   logic                  CTRL_REG_JUMP;
   logic                  CTRL_REG_PC;
   logic                  SEL_MUX;
   logic [1:0]            ULA_PC_SEL;
   logic                  EXEC_VALID;
   logic [DATA_WIDTH-1:0] EXEC_OP;
   logic [DATA_WIDTH-1:0] EXEC_ARG;
   logic                  HALTED;
   logic                  BUSY;

   modport master (
      input  START, INSTR_IN, ARG_IN, EXEC_READY, COND_IN,
      output CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_JUMP, CTRL_REG_PC, SEL_MUX,
             ULA_PC_SEL, EXEC_VALID, EXEC_OP, EXEC_ARG, HALTED, BUSY
   );

   modport slave (
      output START, INSTR_IN, ARG_IN, EXEC_READY, COND_IN,
      input  CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_JUMP, CTRL_REG_PC, SEL_MUX,
             ULA_PC_SEL, EXEC_VALID, EXEC_OP, EXEC_ARG, HALTED, BUSY
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequence FSM: fetch, latch, decode, hand off to execute, update PC.
// Optional retired-instruction counter enabled by macro PAMPY_INSTR_CNT_EN.
module fetch_ctrl #(
   parameter int                   DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] OP_JUMP   = DATA_WIDTH'(113),
   parameter logic [DATA_WIDTH-1:0] OP_JIF    = DATA_WIDTH'(114),
   parameter logic [DATA_WIDTH-1:0] OP_JIT    = DATA_WIDTH'(115),
   parameter logic [DATA_WIDTH-1:0] OP_RET    = DATA_WIDTH'(83),
   parameter logic [DATA_WIDTH-1:0] OP_HALT   = DATA_WIDTH'(0)
) (
   input logic         clk,
   input logic         rst,
   fetch_ctrl_if.master bus
`ifdef PAMPY_INSTR_CNT_EN
   ,
   output logic [31:0] INSTR_COUNT
`endif
);

   typedef enum logic [3:0] {
      IDLE, FETCH, LATCH, DECODE, EXEC, JUMP, PCLD, RET, INC, HALT
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] op_q, arg_q;
   logic                  ld_instr, ld_jump, ld_pc, sel_mux, exec_valid;
   logic [1:0]            ula_sel;
   logic                  take_branch;

   assign take_branch = (op_q == OP_JIF && !bus.COND_IN) ||
                        (op_q == OP_JIT &&  bus.COND_IN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= '0;
         arg_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) begin
            op_q  <= bus.INSTR_IN;
            arg_q <= bus.ARG_IN;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      ld_instr   = 1'b0;
      ld_jump    = 1'b0;
      ld_pc      = 1'b0;
      sel_mux    = 1'b0;
      ula_sel    = 2'b00;
      exec_valid = 1'b0;
      case (state)
         IDLE:   if (bus.START) state_nxt = FETCH;
         FETCH:  state_nxt = LATCH;
         LATCH:  begin ld_instr = 1'b1; state_nxt = DECODE; end
         DECODE: begin
            if      (bus.INSTR_IN == OP_HALT) state_nxt = HALT;
            else if (bus.INSTR_IN == OP_JUMP) state_nxt = JUMP;
            else if (bus.INSTR_IN == OP_RET)  state_nxt = RET;
            else                              state_nxt = EXEC;
         end
         EXEC: begin
            exec_valid = 1'b1;
            if (bus.EXEC_READY) state_nxt = take_branch ? JUMP : INC;
         end
         JUMP:   begin ld_jump = 1'b1; state_nxt = PCLD; end
         PCLD:   begin ld_pc = 1'b1; ula_sel = 2'b10; state_nxt = FETCH; end
         RET:    begin ld_pc = 1'b1; sel_mux = 1'b1; state_nxt = FETCH; end
         INC:    begin ld_pc = 1'b1; ula_sel = 2'b01; state_nxt = FETCH; end
         HALT:   state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are forced low while rst is high, not only after the reset edge.
   assign bus.CTRL_REG_INSTR = ld_instr & ~rst;
   assign bus.CTRL_REG_ARG   = ld_instr & ~rst;
   assign bus.CTRL_REG_JUMP  = ld_jump & ~rst;
   assign bus.CTRL_REG_PC    = ld_pc & ~rst;
   assign bus.SEL_MUX        = sel_mux & ~rst;
   assign bus.ULA_PC_SEL     = rst ? 2'b00 : ula_sel;
   assign bus.EXEC_VALID     = exec_valid & ~rst;
   assign bus.EXEC_OP        = (exec_valid && !rst) ? op_q  : '0;
   assign bus.EXEC_ARG       = (exec_valid && !rst) ? arg_q : '0;
   assign bus.HALTED         = (state == HALT) && !rst;
   assign bus.BUSY           = (state != IDLE) && (state != HALT) && !rst;

`ifdef PAMPY_INSTR_CNT_EN
   logic [31:0] instr_cnt;

   // Every PC update marks one retired instruction; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst)                                 instr_cnt <= '0;
      else if (state inside {INC, PCLD, RET}) instr_cnt <= instr_cnt + 32'd1;
   end

   assign INSTR_COUNT = instr_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a program driver pushes expected bus events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_fetch_ctrl;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.DATA_WIDTH(DW)) bus ();
`ifdef PAMPY_INSTR_CNT_EN
   logic [31:0] instr_count;
`endif

   fetch_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
`ifdef PAMPY_INSTR_CNT_EN
      , .INSTR_COUNT(instr_count)
`endif
   );

   // kind: 0 exec handshake (a=op,b=arg), 1 jump-reg load, 2 PC load (a=sel_mux,b=ula sel), 3 halt
   typedef struct { int kind; int a; int b; } ev_t;
   typedef struct { logic [7:0] op; logic [7:0] arg; logic cond; int wait_n; } ins_t;

   ev_t  exp_q[$];
   ins_t prog[$];
   int   latch_c[$], vrise_c[$], hs_c[$], pc_c[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, start_c = 0, model_pc_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   function automatic void push(input int k, input int a, input int b);
      exp_q.push_back('{k, a, b});
      if (k == 2) model_pc_cnt++;
   endfunction

   // Reference behaviour of one instruction, expressed as the bus events it must produce.
   function automatic void model(input ins_t i);
      bit taken;
      if (i.op == 8'd0)   begin push(3, 0, 0); return; end
      if (i.op == 8'd113) begin push(1, 0, 0); push(2, 0, 2); return; end
      if (i.op == 8'd83)  begin push(2, 1, 0); return; end
      push(0, int'(i.op), int'(i.arg));
      taken = (i.op == 8'd114 && !i.cond) || (i.op == 8'd115 && i.cond);
      if (taken) begin push(1, 0, 0); push(2, 0, 2); end
      else push(2, 0, 1);
   endfunction

   function automatic int ctrl_bits();
      return int'({bus.CTRL_REG_INSTR, bus.CTRL_REG_ARG, bus.CTRL_REG_JUMP, bus.CTRL_REG_PC,
                   bus.SEL_MUX, bus.ULA_PC_SEL, bus.EXEC_VALID});
   endfunction

   task automatic match(input int kind, input int a, input int b);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_event: kind %0d a %0d b %0d with empty queue (cycle %0d)", kind, a, b, cyc);
         return;
      end
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_a", a, e.a);
      chk("ev_b", b, e.b);
   endtask

   // Program driver: plays instruction memory and execute stage.
   initial begin
      ins_t cur;
      int   ecnt;
      cur = '{8'd0, 8'd0, 1'b0, 0};
      ecnt = 0;
      bus.START = 1'b0; bus.INSTR_IN = '0; bus.ARG_IN = '0;
      bus.COND_IN = 1'b0; bus.EXEC_READY = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            bus.EXEC_READY = 1'b0;
            ecnt = 0;
         end else begin
            if (bus.CTRL_REG_INSTR) begin
               if (prog.size() > 0) cur = prog.pop_front();
               else cur = '{8'd0, 8'd0, 1'b0, 0};
               bus.INSTR_IN = cur.op;
               bus.ARG_IN   = cur.arg;
               bus.COND_IN  = cur.cond;
               ecnt = 0;
               model(cur);
            end
            if (bus.EXEC_VALID) begin
               bus.EXEC_READY = (ecnt >= cur.wait_n);
               ecnt++;
            end else begin
               bus.EXEC_READY = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      logic       pv, pr;
      logic [7:0] pop, parg;
      bit         hseen;
      pv = 1'b0; pr = 1'b0; pop = '0; parg = '0; hseen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0; hseen = 1'b0;
         end else begin
            chk("load_onehot", int'((int'(bus.CTRL_REG_INSTR) + int'(bus.CTRL_REG_JUMP) +
                                     int'(bus.CTRL_REG_PC)) <= 1), 1);
            chk("arg_with_instr", int'(bus.CTRL_REG_ARG), int'(bus.CTRL_REG_INSTR));
            if (bus.CTRL_REG_INSTR) latch_c.push_back(cyc);
            if (bus.EXEC_VALID && !pv) vrise_c.push_back(cyc);
            if (pv && !pr) begin
               chk("hold_valid", int'(bus.EXEC_VALID), 1);
               chk("hold_op", int'(bus.EXEC_OP), int'(pop));
               chk("hold_arg", int'(bus.EXEC_ARG), int'(parg));
            end
            if (bus.CTRL_REG_JUMP) match(1, 0, 0);
            if (bus.CTRL_REG_PC) begin
               pc_c.push_back(cyc);
               match(2, int'(bus.SEL_MUX), int'(bus.ULA_PC_SEL));
            end
            if (bus.EXEC_VALID && bus.EXEC_READY) begin
               hs_c.push_back(cyc);
               match(0, int'(bus.EXEC_OP), int'(bus.EXEC_ARG));
            end
            if (bus.HALTED && !hseen) begin hseen = 1'b1; match(3, 0, 0); end
            pv = bus.EXEC_VALID; pr = bus.EXEC_READY; pop = bus.EXEC_OP; parg = bus.EXEC_ARG;
         end
      end
   end

   task automatic clear_logs();
      latch_c.delete(); vrise_c.delete(); hs_c.delete(); pc_c.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      exp_q.delete(); prog.delete(); model_pc_cnt = 0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_ctrl", ctrl_bits(), 0);
         chk("rst_exec_op", int'(bus.EXEC_OP), 0);
         chk("rst_exec_arg", int'(bus.EXEC_ARG), 0);
         chk("rst_halted", int'(bus.HALTED), 0);
         chk("rst_busy", int'(bus.BUSY), 0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", int'(bus.BUSY), 0);
      chk("post_rst_halted", int'(bus.HALTED), 0);
      clear_logs();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start_c = cyc;
      bus.START = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0;
   endtask

   // Runs the queued program (HALT appended implicitly) and checks the halted state.
   task automatic run_prog(input bit rand_start);
      int n;
      pulse_start();
      n = 0;
      while (!bus.HALTED && n < 3000) begin
         @(posedge clk); #1;
         if (rand_start) bus.START = ($urandom_range(0, 3) == 0);
         n++;
      end
      bus.START = 1'b0;
      chk("halt_reached", int'(bus.HALTED), 1);
      repeat (3) begin
         @(posedge clk); #1; bus.START = 1'b1;
         @(negedge clk);
         chk("halt_ctrl", ctrl_bits(), 0);
         chk("halt_busy", int'(bus.BUSY), 0);
         chk("halt_hold", int'(bus.HALTED), 1);
      end
      bus.START = 1'b0;
      chk("exp_drained", exp_q.size(), 0);
   endtask

   function automatic ins_t rnd_ins();
      ins_t i;
      case ($urandom_range(0, 9))
         0: i.op = 8'd113;
         1: i.op = 8'd114;
         2: i.op = 8'd115;
         3: i.op = 8'd83;
         default: i.op = 8'($urandom_range(1, 255));
      endcase
      i.arg = 8'($urandom_range(0, 255));
      i.cond = 1'($urandom_range(0, 1));
      i.wait_n = $urandom_range(0, 3);
      return i;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      do_reset();

      // Plain op, ready already high: exact cycle positions relative to START
      prog.push_back('{8'd100, 8'd5, 1'b0, 0});
      run_prog(1'b0);
      chk("t_latch", at(latch_c, 0) - start_c, 2);
      chk("t_valid", at(vrise_c, 0) - start_c, 4);
      chk("t_hs", at(hs_c, 0) - start_c, 4);
      chk("t_inc", at(pc_c, 0) - start_c, 5);
      chk("t_next_latch", at(latch_c, 1) - start_c, 7);

      // JIF not-taken condition, execute stalls three cycles, then taken jump
      do_reset();
      prog.push_back('{8'd114, 8'd7, 1'b0, 3});
      run_prog(1'b0);
      chk("jif_valid_len", at(hs_c, 0) - at(vrise_c, 0), 3);
      chk("jif_pcld_after", at(pc_c, 0) - at(hs_c, 0), 2);
      chk("jif_cost", at(latch_c, 1) - at(latch_c, 0), 9);

      // JIT not taken, JIF with true condition, JUMP, RET
      do_reset();
      prog.push_back('{8'd115, 8'd1, 1'b0, 0});
      prog.push_back('{8'd114, 8'd2, 1'b1, 1});
      prog.push_back('{8'd113, 8'd3, 1'b0, 0});
      prog.push_back('{8'd83,  8'd4, 1'b0, 0});
      run_prog(1'b1);
      chk("jump_cost", at(latch_c, 3) - at(latch_c, 2), 5);
      chk("nontaken_cost", at(latch_c, 1) - at(latch_c, 0), 5);

      // Reset in the middle of an execute handshake
      do_reset();
      prog.push_back('{8'd100, 8'd1, 1'b0, 20});
      pulse_start();
      n = 0;
      while (!bus.EXEC_VALID && n < 50) begin @(posedge clk); #1; n++; end
      chk("exec_reached", int'(bus.EXEC_VALID), 1);
      #1;
      rst = 1'b1;
      exp_q.delete(); prog.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", int'(bus.EXEC_VALID), 0);
      chk("mid_rst_busy", int'(bus.BUSY), 0);
      clear_logs();
      prog.push_back('{8'd101, 8'd9, 1'b0, 0});
      run_prog(1'b0);
      chk("restart_latch", at(latch_c, 0) - start_c, 2);

      // Randomized programs
      for (int p = 0; p < 15; p++) begin
         do_reset();
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) prog.push_back(rnd_ins());
         run_prog(1'b1);
`ifdef PAMPY_INSTR_CNT_EN
         chk("cnt_random", int'(instr_count), model_pc_cnt);
`endif
      end

`ifdef PAMPY_INSTR_CNT_EN
      do_reset();
      prog.push_back('{8'd100, 8'd1, 1'b0, 0});
      prog.push_back('{8'd101, 8'd2, 1'b0, 1});
      prog.push_back('{8'd102, 8'd3, 1'b0, 0});
      prog.push_back('{8'd113, 8'd4, 1'b0, 0});
      run_prog(1'b0);
      chk("cnt_four", int'(instr_count), 4);
      do_reset();
      force dut.instr_cnt = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut.instr_cnt;
      prog.push_back('{8'd100, 8'd1, 1'b0, 0});
      run_prog(1'b0);
      chk("cnt_wrap", int'(instr_count), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
